// File: rtl/shift_pkg.sv
// Shared definitions for the serial shift link: receiver FSM states and the
// bit-order select encoding used by both ends of the link.
package shift_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // Same encodings as the transmitter's left/right shift selects
  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_deserializer_if.sv
// Serial-in / parallel-out bundle of the shift deserializer.
// master = link driver and consumer, slave = deserializer.
interface shift_deserializer_if #(
  parameter int WIDTH = 5
);
  logic             bit_valid;
  logic             si;
  logic             dir;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;

  modport master (
    output bit_valid, si, dir, out_ready,
    input  out, out_valid, busy, overrun
  );

  modport slave (
    input  bit_valid, si, dir, out_ready,
    output out, out_valid, busy, overrun
  );
endinterface

// File: rtl/shift_deserializer.sv
// Receiver for the serial shift link: assembles WIDTH-bit words in either bit
// order and presents them through a one-entry valid/ready holding register.
module shift_deserializer
  import shift_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_deserializer_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic             dir_q, dir_n;
  logic             eff_dir;
  logic             complete;

  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;
  logic             overrun_q;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sreg_n   = sreg;
    dir_n    = dir_q;
    complete = 1'b0;
    // The first bit of a word shifts with the live dir, later bits with dir_q
    eff_dir  = (state == IDLE) ? bus.dir : dir_q;

    if (bus.bit_valid) begin
      if (eff_dir == DIR_LSB_FIRST) sreg_n = {bus.si, sreg[WIDTH-1:1]};
      else                          sreg_n = {sreg[WIDTH-2:0], bus.si};

      case (state)
        IDLE: begin
          dir_n   = bus.dir;
          cnt_n   = CW'(1);
          state_n = SHIFT;
        end
        SHIFT: begin
          if (cnt == CW'(WIDTH - 1)) begin
            complete = 1'b1;
            cnt_n    = '0;
            state_n  = IDLE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
      dir_q <= DIR_MSB_FIRST;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sreg  <= sreg_n;
      dir_q <= dir_n;
    end
  end

  // Holding register: a completion may refill in the same cycle the old word leaves
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (complete) begin
      if (!out_valid_q || bus.out_ready) begin
        out_q       <= sreg_n;
        out_valid_q <= 1'b1;
      end else begin
        overrun_q <= 1'b1;
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state == SHIFT);

endmodule

// File: doc/shift_deserializer.md
# shift_deserializer

- Receiving end of the team's serial shift link.
- Accepts the 1-bit stream produced by the universal shift register's serial output, one bit per qualified clock, and assembles WIDTH-bit words in either bit order.
- Presents each completed word through a one-entry holding register with a valid/ready handshake, and flags overruns.
- Sits between the serial link and any parallel consumer: register file, FIFO or checker.

## Interface
Parameters:
- WIDTH, 5, word length in bits (>= 2)

Ports:
- clk, input, 1, sole clock; all state updates on rising edge
- rst, input, 1, synchronous, active-high reset
- bit_valid, input, 1, si carries a valid bit this cycle
- si, input, 1, serial data bit
- dir, input, 1, bit order: 0 = MSB first (shift-left order), 1 = LSB first (shift-right order); sampled with the first bit of each word
- out, output, WIDTH, completed word (holding register)
- out_valid, output, 1, out holds an unconsumed word
- out_ready, input, 1, consumer accepts out this cycle
- busy, output, 1, a word is partially received
- overrun, output, 1, sticky: a completed word was dropped

## Operation
- FSM states: IDLE, SHIFT.
- IDLE:
  - bit_valid=1 → capture dir into dir_q, shift si into sreg, set cnt=1, go to SHIFT.
  - bit_valid=0 → stay in IDLE.
- SHIFT:
  - Each bit_valid=1 shifts one bit and increments cnt.
  - bit_valid=0 cycles are gaps: no state change; any gap length is allowed.
- Shift rule:
  - dir_q=0: sreg <= {sreg[WIDTH-2:0], si}.
  - dir_q=1: sreg <= {si, sreg[WIDTH-1:1]}.
  - For the first bit, use the incoming dir value, not dir_q.
- Completion: on the WIDTH-th valid bit (cnt == WIDTH-1 before the shift), the fully shifted word is the completed word; FSM returns to IDLE and cnt clears.
- Holding register:
  - On completion with out_valid=0, or with out_valid=1 and out_ready=1 in the same cycle: out <= completed word, out_valid=1.
  - On completion with out_valid=1 and out_ready=0: word dropped, out unchanged, overrun <= 1.
  - out_ready=1 with out_valid=1 and no completion: out_valid <= 0; out keeps its last value.
  - out_ready while out_valid=0 is ignored.
- overrun clears only on rst.
- dir changes mid-word have no effect until the next word.
- busy = (state == SHIFT).
- cnt width: $clog2(WIDTH); it never exceeds WIDTH-1.

## Timing
- Reset values: out=0, out_valid=0, busy=0, overrun=0, state=IDLE, cnt=0, sreg=0.
- Reset mid-word discards the partial word.
- Reset while out_valid=1 discards the held word.
- Latency: out_valid rises on the clock edge that samples the WIDTH-th valid bit. The word is visible the cycle after that bit is presented.
- Back-to-back words:
  - Sustained throughput is one bit per cycle; no dead cycle between words.
  - A new word may start in the cycle right after completion.
- Handshake: the transfer occurs on an edge where out_valid=1 and out_ready=1. out holds stable while out_valid=1 and out_ready=0.
- Simultaneous completion + out_ready: the old word is consumed, the new one loaded, out_valid stays 1, no overrun.
- No combinational path from any input to any output.

## Structure
- Shared package (shift_pkg):
  - state enum {IDLE, SHIFT}
  - dir constants DIR_MSB_FIRST=0, DIR_LSB_FIRST=1, matching the transmitter's left/right select encodings
- Single flat module; no sub-module.
- Holding register and FSM live in one file.

## Test plan
- WIDTH=5, dir=0, bits 1,0,1,1,0 on consecutive cycles, out_ready=1 → out=5'b10110, out_valid high one cycle.
- dir=1, same bits → out=5'b01101.
- dir=0, bits 1,1,0,0,1 with 2-cycle gaps between bits; dir toggled mid-word → out=5'b11001, busy high from bit 1 until completion.
- out_ready=0, two full words 5'b10101 then 5'b00011 → out stays 10101, overrun=1. Then out_ready=1 → out_valid drops; overrun stays 1 until rst.
- Completion of 5'b11110 in the same cycle out_ready=1 consumes the held 5'b00001 → out=11110, out_valid stays 1, overrun=0.
- rst asserted after 3 bits of a word → busy=0, out_valid=0. Next 5 bits 0,0,1,1,1 (dir=0) → out=5'b00111.
